// File: rtl/enemy_move_control.sv
// Moore control FSM for one falling enemy sprite: spawn, draw 4x4, hold, erase, step down.
// Outputs are decoded from registered state only; the datapath supplies cnt and delay_cnt.
module enemy_move_control #(
    parameter int Y_STEPS    = 116,
    parameter int HOLD_TICKS = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       run,
    input  logic       hit,
    input  logic [3:0] cnt,
    input  logic [3:0] delay_cnt,
    output logic       loadX,
    output logic       load_colour,
    output logic       loadY,
    output logic       load_black,
    output logic       en_counter,
    output logic       en_delay_counter,
    output logic       reset_delay,
    output logic       plot,
    output logic       escaped,
    output logic       killed
);

    localparam logic [6:0] LAST_STEP = 7'(Y_STEPS - 1);
    localparam logic [3:0] HOLD_C    = 4'(HOLD_TICKS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        LOAD_C = 3'd2,
        DRAW   = 3'd3,
        WAIT   = 3'd4,
        ERASE  = 3'd5,
        MOVE   = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] step_q, step_d;
    logic       hit_pending_q, hit_pending_d;

    // State, step counter and pending-hit flag registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= IDLE;
            step_q        <= 7'd0;
            hit_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            hit_pending_q <= hit_pending_d;
        end
    end

    // Next-state, step and hit bookkeeping
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        hit_pending_d = hit_pending_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = LOAD_X;
                else     state_d = IDLE;
            end
            LOAD_X: begin
                step_d        = 7'd0;
                hit_pending_d = 1'b0;
                state_d       = LOAD_C;
            end
            LOAD_C: state_d = DRAW;
            DRAW: begin
                if (hit) hit_pending_d = 1'b1;
                else     hit_pending_d = hit_pending_q;
                if (cnt == 4'd15) state_d = WAIT;
                else              state_d = DRAW;
            end
            WAIT: begin
                if (hit) hit_pending_d = 1'b1;
                else     hit_pending_d = hit_pending_q;
                if (delay_cnt >= HOLD_C) state_d = ERASE;
                else                     state_d = WAIT;
            end
            ERASE: begin
                if (hit) hit_pending_d = 1'b1;
                else     hit_pending_d = hit_pending_q;
                if (cnt == 4'd15) state_d = MOVE;
                else              state_d = ERASE;
            end
            MOVE: begin
                // kill and escape both end this enemy; otherwise step one row down
                if (hit_pending_q || (step_q == LAST_STEP)) begin
                    if (run) state_d = LOAD_X;
                    else     state_d = IDLE;
                end else begin
                    step_d = step_q + 7'd1;
                    if (run) state_d = DRAW;
                    else     state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode from registered state
    always_comb begin
        loadX            = 1'b0;
        load_colour      = 1'b0;
        loadY            = 1'b0;
        load_black       = 1'b0;
        en_counter       = 1'b0;
        en_delay_counter = 1'b0;
        reset_delay      = 1'b0;
        plot             = 1'b0;
        escaped          = 1'b0;
        killed           = 1'b0;
        case (state_q)
            LOAD_X: loadX = 1'b1;
            LOAD_C: load_colour = 1'b1;
            DRAW: begin
                en_counter = 1'b1;
                plot       = 1'b1;
            end
            WAIT: begin
                reset_delay      = 1'b1;
                en_delay_counter = 1'b1;
            end
            ERASE: begin
                load_black = 1'b1;
                en_counter = 1'b1;
                plot       = 1'b1;
            end
            MOVE: begin
                if (hit_pending_q)            killed  = 1'b1;
                else if (step_q == LAST_STEP) escaped = 1'b1;
                else                          loadY   = 1'b1;
            end
            default: loadX = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_enemy_move_control.sv
// Bench for enemy_move_control: a phase/pixel/row model of one enemy's life plus a
// bench-side datapath (pixel and delay counters), directed scenarios then random play.
module tb_enemy_move_control;

    localparam int YS   = 3;
    localparam int HOLD = 1;

    localparam int M_IDLE  = 0;
    localparam int M_LOADX = 1;
    localparam int M_LOADC = 2;
    localparam int M_DRAW  = 3;
    localparam int M_WAIT  = 4;
    localparam int M_ERASE = 5;
    localparam int M_MOVE  = 6;

    logic       clock = 1'b0;
    logic       resetn, run, hit;
    logic [3:0] cnt, delay_cnt;
    logic       loadX, load_colour, loadY, load_black, en_counter;
    logic       en_delay_counter, reset_delay, plot, escaped, killed;

    enemy_move_control #(.Y_STEPS(YS), .HOLD_TICKS(HOLD)) dut (
        .clock(clock), .resetn(resetn), .run(run), .hit(hit),
        .cnt(cnt), .delay_cnt(delay_cnt),
        .loadX(loadX), .load_colour(load_colour), .loadY(loadY),
        .load_black(load_black), .en_counter(en_counter),
        .en_delay_counter(en_delay_counter), .reset_delay(reset_delay),
        .plot(plot), .escaped(escaped), .killed(killed)
    );

    always #5 clock = ~clock;

    // model of the enemy: which phase, pixel within sprite, rows moved, shot flag
    int ph = M_IDLE;
    int px = 0;
    int row = 0;
    bit shot = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_loadx, n_loady, n_esc, n_kill, n_plot;
    int first_lx = -1;
    int first_esc = -1;
    bit tick = 1'b1;
    logic [9:0] last_got;

    // bit order: loadX load_colour loadY load_black en_counter en_delay reset_delay plot escaped killed
    function automatic logic [9:0] expected();
        logic [9:0] e;
        e = 10'd0;
        case (ph)
            M_LOADX: e[9] = 1'b1;
            M_LOADC: e[8] = 1'b1;
            M_DRAW:  begin e[5] = 1'b1; e[2] = 1'b1; end
            M_WAIT:  begin e[4] = 1'b1; e[3] = 1'b1; end
            M_ERASE: begin e[6] = 1'b1; e[5] = 1'b1; e[2] = 1'b1; end
            M_MOVE: begin
                if (shot)              e[0] = 1'b1;
                else if (row == YS - 1) e[1] = 1'b1;
                else                   e[7] = 1'b1;
            end
            default: e = 10'd0;
        endcase
        return e;
    endfunction

    task automatic model_step();
        if (!resetn) begin
            ph = M_IDLE; px = 0; row = 0; shot = 1'b0;
        end else begin
            if (hit && (ph == M_DRAW || ph == M_WAIT || ph == M_ERASE)) shot = 1'b1;
            case (ph)
                M_IDLE:  if (run) ph = M_LOADX;
                M_LOADX: begin row = 0; shot = 1'b0; ph = M_LOADC; end
                M_LOADC: begin px = 0; ph = M_DRAW; end
                M_DRAW:  if (px == 15) begin px = 0; ph = M_WAIT; end else px++;
                M_WAIT:  if (int'(delay_cnt) >= HOLD) ph = M_ERASE;
                M_ERASE: if (px == 15) begin px = 0; ph = M_MOVE; end else px++;
                M_MOVE: begin
                    if (shot || row == YS - 1) ph = run ? M_LOADX : M_IDLE;
                    else begin row++; ph = run ? M_DRAW : M_IDLE; end
                end
                default: ph = M_IDLE;
            endcase
        end
    endtask

    task automatic reset_stats();
        n_loadx = 0; n_loady = 0; n_esc = 0; n_kill = 0; n_plot = 0;
    endtask

    task automatic pin(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // one clock: check outputs mid-cycle, advance model and bench datapath
    task automatic cycle();
        logic [9:0] got, exp;
        logic [3:0] cnt_n, dly_n;
        @(negedge clock);
        got = {loadX, load_colour, loadY, load_black, en_counter,
               en_delay_counter, reset_delay, plot, escaped, killed};
        exp = expected();
        last_got = got;
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL outputs cyc=%0d phase=%0d: got %b, expected %b", cyc, ph, got, exp);
        end
        if (loadX)   n_loadx++;
        if (loadY)   n_loady++;
        if (escaped) n_esc++;
        if (killed)  n_kill++;
        if (plot)    n_plot++;
        if (loadX && first_lx < 0)    first_lx = cyc;
        if (escaped && first_esc < 0) first_esc = cyc;
        if (!resetn) begin
            cnt_n = 4'd0; dly_n = 4'd0;
        end else begin
            cnt_n = en_counter ? cnt + 4'd1 : cnt;
            if (!reset_delay)                 dly_n = 4'd0;
            else if (en_delay_counter && tick) dly_n = delay_cnt + 4'd1;
            else                              dly_n = delay_cnt;
        end
        model_step();
        cyc++;
        @(posedge clock);
        #1;
        cnt = cnt_n;
        delay_cnt = dly_n;
    endtask

    initial begin
        bit hw_done;
        bit found;
        resetn = 1'b0; run = 1'b0; hit = 1'b0; cnt = 4'd0; delay_cnt = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        reset_stats();
        cycle();

        // life 1: no hits, delay ticks every cycle, enemy must escape after 3 rows
        resetn = 1'b1; run = 1'b1; tick = 1'b1;
        repeat (109) cycle();
        pin("first_loadx_cycle", first_lx, 2);
        pin("escape_cycle", first_esc, 108);
        pin("life1_loadY", n_loady, 2);
        pin("life1_escaped", n_esc, 1);
        pin("life1_plots", n_plot, 96);
        pin("life1_respawn", n_loadx, 2);

        // life 2: hit in WAIT and in ERASE of first move, also in LOAD_X
        reset_stats();
        hw_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            hit = (ph == M_WAIT && !hw_done) || (ph == M_ERASE && px == 3) || (ph == M_LOADX);
            if (ph == M_WAIT) hw_done = 1'b1;
            cycle();
        end
        hit = 1'b0;
        pin("life2_killed", n_kill, 1);
        pin("life2_loadY", n_loady, 0);
        pin("life2_escaped", n_esc, 0);

        // run dropped mid-DRAW: finish move, one loadY, park
        reset_stats();
        run = 1'b0;
        repeat (70) cycle();
        pin("park_loadY", n_loady, 1);
        pin("park_loadX", n_loadx, 0);
        pin("park_escaped", n_esc + n_kill, 0);
        reset_stats();
        run = 1'b1;
        repeat (3) cycle();
        pin("restart_loadX", n_loadx, 1);

        // reset pulse at pixel 7 of ERASE
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (ph == M_ERASE && px == 7) found = 1'b1;
            else cycle();
        end
        pin("erase_px7_reached", int'(found), 1);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        cycle();
        pin("after_reset_outputs", int'(last_got), 0);

        // random play
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) run = ~run;
            hit    = ($urandom_range(0, 99) < 3);
            resetn = ($urandom_range(0, 999) >= 3);
            tick   = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/enemy_move_control.md
Name: enemy_move_control

Overview:
- Moore control FSM that sequences one falling enemy sprite through its drawing datapath: load column, latch colour, draw 4x4, hold, erase, step down, repeat.
- Sits directly upstream of the enemy drawing datapath. Drives that datapath's load/enable strobes and reads back its pixel counter (cnt) and frame-delay counter (delay_cnt).
- Also raises the VGA plot strobe and reports enemy-escaped / enemy-killed events to the game/score logic.

Parameters:
- Y_STEPS, 116, number of one-pixel downward moves before the enemy counts as escaped (bottom of the 120-row screen minus sprite height 4).
- HOLD_TICKS, 1, number of delay_cnt increments the sprite stays visible before erase (1..15).

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- run  in  1  game running; low parks the FSM in IDLE
- hit  in  1  single-cycle pulse: a bullet hit this enemy
- cnt  in  4  pixel counter from the datapath; {row[1:0],col[1:0]} of the 4x4 sprite
- delay_cnt  in  4  frame-delay tick counter from the datapath
- loadX  out  1  load a new column and reset Y to 0
- load_colour  out  1  latch sprite colour from the new column
- loadY  out  1  move the sprite down one row
- load_black  out  1  force colour 0 (erase)
- en_counter  out  1  advance the pixel counter
- en_delay_counter  out  1  run the frame-delay prescaler
- reset_delay  out  1  active-low clear of delay_cnt
- plot  out  1  VGA write enable for the current pixel
- escaped  out  1  one-cycle pulse: enemy reached the bottom
- killed  out  1  one-cycle pulse: enemy removed by a hit

Behaviour:
- States: IDLE, LOAD_X, LOAD_C, DRAW, WAIT, ERASE, MOVE.
- Outputs are decoded from the state register only (Moore). Every output defaults to 0 unless listed for the current state.
- Reset: state=IDLE, step=0, hit_pending=0. All outputs are 0, including reset_delay (delay_cnt is held cleared).
- IDLE: go to LOAD_X when run=1.
- LOAD_X: loadX=1; clear step and hit_pending; go to LOAD_C.
- LOAD_C: load_colour=1, issued one cycle after loadX so the colour uses the updated column; go to DRAW.
- DRAW: en_counter=1, plot=1. When cnt==15, go to WAIT. Exactly 16 plot cycles; cnt wraps to 0 on exit.
- WAIT: reset_delay=1, en_delay_counter=1. When delay_cnt>=HOLD_TICKS, go to ERASE.
- ERASE: load_black=1, en_counter=1, plot=1. When cnt==15, go to MOVE. Exactly 16 plot cycles.
- MOVE, evaluated in priority order:
  - hit_pending=1: killed=1, no loadY; next state is LOAD_X if run=1, else IDLE.
  - step==Y_STEPS-1: escaped=1, no loadY; next state is LOAD_X if run=1, else IDLE.
  - run=0: loadY=1, step++, go to IDLE.
  - otherwise: loadY=1, step++, go to DRAW.
- reset_delay=0 in every state except WAIT, so delay_cnt restarts from 0 on each WAIT entry.
- hit handling: hit=1 in DRAW, WAIT or ERASE sets hit_pending. A hit in any other state is ignored. Multiple hits before MOVE produce a single killed pulse.
- The sprite is always fully erased before any respawn or park, so a dropped run never leaves stale pixels.
- step is 7 bits and never wraps, because it is cleared in LOAD_X.
- resetn low in any state (including mid-DRAW or mid-ERASE) returns the FSM to IDLE on the next edge. The datapath is reset by the same resetn.
- Timing per move with HOLD_TICKS=h: 16 (DRAW) + WAIT time + 16 (ERASE) + 1 (MOVE) cycles. Spawn overhead is 2 cycles (LOAD_X, LOAD_C).

Test Plan:
- Reset then run=1, HOLD_TICKS=1: IDLE -> LOAD_X (1 cycle) -> LOAD_C (1 cycle) -> DRAW. plot is high for exactly 16 cycles while cnt goes 0..15. WAIT exits on the cycle where delay_cnt reaches 1.
- ERASE/MOVE: after WAIT, load_black=plot=1 for 16 cycles, then a single-cycle loadY, then DRAW re-entered with cnt=0.
- Y_STEPS=3: exactly 2 loadY pulses, then the third MOVE gives escaped=1 with loadY=0, followed by loadX=1 on the next cycle.
- Pulse hit once in WAIT and once in ERASE of the same move: one killed pulse at MOVE, no loadY, then LOAD_X. escaped stays 0.
- run dropped during DRAW: the FSM still completes WAIT and 16 ERASE plots, pulses loadY in MOVE, then reaches IDLE and stays there with plot=0. Raising run restarts at LOAD_X.
- resetn low for 1 cycle at cnt=7 in ERASE: next state IDLE with all outputs 0. The bench also checks that hit during IDLE or LOAD_X never produces killed.
